per2axi_rsp_channel: RTL



---
 rtl/per2axi_rsp_channel.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/per2axi_rsp_channel.sv
// per2axi_rsp_channel
// Response stage of the peripheral-to-AXI bridge. It keeps a per-ID read
// context table so the correct 32-bit half of each 64-bit R beat is returned.
// It also arbitrates the AXI R and B channels onto the single, unstallable
// peripheral response port, with one registered response per cycle.

module per2axi_rsp_channel #(
   parameter int unsigned PER_ID_WIDTH   = 5,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_USER_WIDTH = 6,
   parameter int unsigned AXI_ID_WIDTH   = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,

   output logic                      per_slave_r_valid_o,
   output logic                      per_slave_r_opc_o,
   output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
   output logic [31:0]               per_slave_r_rdata_o,

   input  logic                      axi_master_r_valid_i,
   input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
   input  logic [1:0]                axi_master_r_resp_i,
   input  logic                      axi_master_r_last_i,
   input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
   input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
   output logic                      axi_master_r_ready_o,

   input  logic                      axi_master_b_valid_i,
   input  logic [1:0]                axi_master_b_resp_i,
   input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
   input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
   output logic                      axi_master_b_ready_o,

   input  logic                      trans_req_i,
   input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
   input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i
);

   localparam int unsigned N_IDS = 2 ** AXI_ID_WIDTH;

   // Context table: address bit 2 and outstanding flag per AXI ID.
   logic [N_IDS-1:0]        hi_q, hi_d;
   logic [N_IDS-1:0]        pend_q, pend_d;
   // Previous arbitration winner: 1 = R, 0 = B.
   logic                    last_r_q, last_r_d;

   logic                    valid_q, valid_d;
   logic                    opc_q, opc_d;
   logic [PER_ID_WIDTH-1:0] id_q, id_d;
   logic [31:0]             rdata_q, rdata_d;

   logic                    r_win_s;
   logic                    b_win_s;

   // Binary AXI ID to one-hot peripheral ID; IDs beyond the port width give zero.
   function automatic logic [PER_ID_WIDTH-1:0] onehot_id(input logic [AXI_ID_WIDTH-1:0] id);
      logic [PER_ID_WIDTH-1:0] oh;
      for (int i = 0; i < int'(PER_ID_WIDTH); i++) begin
         if (int'(id) == i) begin
            oh[i] = 1'b1;
         end else begin
            oh[i] = 1'b0;
         end
      end
      return oh;
   endfunction

   // Round-robin choice between R and B; no channel is granted while in reset.
   always_comb begin
      r_win_s = 1'b0;
      b_win_s = 1'b0;
      if (!rst_ni) begin
         r_win_s = 1'b0;
         b_win_s = 1'b0;
      end else if (axi_master_r_valid_i && (!axi_master_b_valid_i || !last_r_q)) begin
         r_win_s = 1'b1;
      end else if (axi_master_b_valid_i) begin
         b_win_s = 1'b1;
      end else begin
         r_win_s = 1'b0;
         b_win_s = 1'b0;
      end
   end

   assign axi_master_r_ready_o = r_win_s;
   assign axi_master_b_ready_o = b_win_s;

   // Build the next peripheral response from whichever channel won this cycle.
   always_comb begin
      valid_d  = 1'b0;
      opc_d    = opc_q;
      id_d     = id_q;
      rdata_d  = rdata_q;
      last_r_d = last_r_q;
      if (r_win_s) begin
         valid_d  = 1'b1;
         opc_d    = axi_master_r_resp_i[1];
         id_d     = onehot_id(axi_master_r_id_i);
         last_r_d = 1'b1;
         if (hi_q[axi_master_r_id_i]) begin
            rdata_d = axi_master_r_data_i[63:32];
         end else begin
            rdata_d = axi_master_r_data_i[31:0];
         end
      end else if (b_win_s) begin
         valid_d  = 1'b1;
         opc_d    = axi_master_b_resp_i[1];
         id_d     = onehot_id(axi_master_b_id_i);
         last_r_d = 1'b0;
         // EXOKAY reports a successful store-conditional as 0.
         if (axi_master_b_resp_i == 2'b01) begin
            rdata_d = 32'h0000_0000;
         end else begin
            rdata_d = 32'h0000_0001;
         end
      end else begin
         valid_d = 1'b0;
      end
   end

   // Table maintenance: an accepted R retires its ID, a newly issued read
   // re-arms it; the issue is applied last so it wins on a same-ID collision.
   always_comb begin
      hi_d   = hi_q;
      pend_d = pend_q;
      if (r_win_s) begin
         pend_d[axi_master_r_id_i] = 1'b0;
      end else begin
         pend_d = pend_q;
      end
      if (trans_req_i) begin
         hi_d[trans_id_i]   = trans_add_i[2];
         pend_d[trans_id_i] = 1'b1;
      end else begin
         hi_d = hi_q;
      end
   end

   // State and registered response outputs, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_q     <= {N_IDS{1'b0}};
         pend_q   <= {N_IDS{1'b0}};
         last_r_q <= 1'b0;
         valid_q  <= 1'b0;
         opc_q    <= 1'b0;
         id_q     <= {PER_ID_WIDTH{1'b0}};
         rdata_q  <= 32'h0000_0000;
      end else begin
         hi_q     <= hi_d;
         pend_q   <= pend_d;
         last_r_q <= last_r_d;
         valid_q  <= valid_d;
         opc_q    <= opc_d;
         id_q     <= id_d;
         rdata_q  <= rdata_d;
      end
   end

   assign per_slave_r_valid_o = valid_q;
   assign per_slave_r_opc_o   = opc_q;
   assign per_slave_r_id_o    = id_q;
   assign per_slave_r_rdata_o = rdata_q;

   // Inputs carried for port compatibility only.
   logic unused_s;
   assign unused_s = ^{axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i,
                       trans_add_i[AXI_ADDR_WIDTH-1:3], trans_add_i[1:0]};

endmodule
